alu_issue_stage: RTL and testbench

Decode/issue stage that drives the ALU's operand and opcode interface (`lhs`, `rhs`, 4-bit `op`). It accepts an RV32I instruction word with its PC and register-file read values, and decodes the OP, OP-IMM, LUI and AUIPC classes. It emits one registered ALU transaction per accepted instruction over a valid/ready handshake, and keeps a wrapping count of issued transactions.

---
 rtl/alu_issue_stage.sv | 149 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM/LUI/AUIPC decode and ALU issue register
// One registered ALU transaction per accepted instruction, valid/ready on both sides.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [31:0]      out_lhs,
  output logic [31:0]      out_rhs,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issued_count
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  logic [3:0]  dec_op;
  logic [31:0] dec_lhs;
  logic [31:0] dec_rhs;
  logic        dec_illegal;
  logic        accept;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign shamt  = {27'b0, in_inst[24:20]};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // funct3 encodings for the non-alternate ops line up with ALU codes 0..7.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_lhs     = 32'b0;
    dec_rhs     = 32'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_lhs = in_rs1;
        dec_rhs = in_rs2;
        if (funct7 == F7_BASE) begin
          dec_op = {1'b0, funct3};
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_lhs = in_rs1;
        case (funct3)
          3'b001: begin
            dec_rhs     = shamt;
            dec_op      = ALU_SLL;
            dec_illegal = (funct7 != F7_BASE);
          end
          3'b101: begin
            dec_rhs = shamt;
            if (funct7 == F7_BASE) begin
              dec_op = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_op = ALU_SRA;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: begin
            dec_rhs = imm_i;
            dec_op  = {1'b0, funct3};
          end
        endcase
      end
      OPC_LUI: begin
        dec_rhs = imm_u;
      end
      OPC_AUIPC: begin
        dec_lhs = in_pc;
        dec_rhs = imm_u;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
    // Illegal transactions carry a neutral payload so the ALU never sees stale operands.
    if (dec_illegal) begin
      dec_op  = ALU_ADD;
      dec_lhs = 32'b0;
      dec_rhs = 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_op       <= 4'b0;
      out_lhs      <= 32'b0;
      out_rhs      <= 32'b0;
      out_rd       <= 5'b0;
      out_illegal  <= 1'b0;
      issued_count <= '0;
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_op      <= dec_op;
        out_lhs     <= dec_lhs;
        out_rhs     <= dec_rhs;
        out_rd      <= in_inst[11:7];
        out_illegal <= dec_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        issued_count <= issued_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
// Directed cases from the instruction set rules, then randomized traffic with random backpressure.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_op;
  logic [31:0] out_lhs;
  logic [31:0] out_rhs;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] issued_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [3:0]  out_op2;
  logic [31:0] out_lhs2;
  logic [31:0] out_rhs2;
  logic [4:0]  out_rd2;
  logic        out_illegal2;
  logic [1:0]  issued_count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs = 0;
  bit armed = 0;
  bit rst_d = 0;
  bit rand_rdy = 0;
  bit force_rdy = 1;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  alu_issue_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_lhs(out_lhs), .out_rhs(out_rhs), .out_rd(out_rd),
    .out_illegal(out_illegal), .issued_count(issued_count)
  );

  alu_issue_stage #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_op(out_op2),
    .out_lhs(out_lhs2), .out_rhs(out_rhs2), .out_rd(out_rd2),
    .out_illegal(out_illegal2), .issued_count(issued_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference decode: classify the instruction into a mnemonic, then map mnemonic to ALU code.
  typedef enum {M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND, M_SUB, M_SRA, M_ILL} mn_t;

  function automatic logic [3:0] alu_code(input mn_t m);
    case (m)
      M_ADD:   return 4'd0;
      M_SLL:   return 4'd1;
      M_SLT:   return 4'd2;
      M_SLTU:  return 4'd3;
      M_XOR:   return 4'd4;
      M_SRL:   return 4'd5;
      M_OR:    return 4'd6;
      M_AND:   return 4'd7;
      M_SUB:   return 4'd8;
      M_SRA:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    mn_t by_f3 [8] = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
    exp_t e;
    mn_t m = M_ILL;
    int f3 = int'(inst[14:12]);
    int f7 = int'(inst[31:25]);
    int opc = int'(inst[6:0]);
    logic [31:0] l = 0;
    logic [31:0] r = 0;
    if (opc == 'h33) begin
      l = a; r = b;
      if (f7 == 0) m = by_f3[f3];
      else if (f7 == 'h20 && f3 == 0) m = M_SUB;
      else if (f7 == 'h20 && f3 == 5) m = M_SRA;
    end else if (opc == 'h13) begin
      l = a;
      if (f3 == 1 || f3 == 5) begin
        r = 32'(inst[24:20]);
        if (f7 == 0) m = (f3 == 1) ? M_SLL : M_SRL;
        else if (f7 == 'h20 && f3 == 5) m = M_SRA;
      end else begin
        r = 32'($signed(inst) >>> 20);
        m = by_f3[f3];
      end
    end else if (opc == 'h37) begin
      r = inst & 32'hFFFF_F000;
      m = M_ADD;
    end else if (opc == 'h17) begin
      l = pc;
      r = inst & 32'hFFFF_F000;
      m = M_ADD;
    end
    e.rd = inst[11:7];
    e.ill = (m == M_ILL);
    e.op = alu_code(m);
    e.lhs = e.ill ? 32'h0 : l;
    e.rhs = e.ill ? 32'h0 : r;
    return e;
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_d) begin
        check("rst_out_op", 32'(out_op), 0);
        check("rst_out_lhs", out_lhs, 0);
        check("rst_out_rhs", out_rhs, 0);
        check("rst_out_rd", 32'(out_rd), 0);
        check("rst_out_illegal", 32'(out_illegal), 0);
        check("rst_in_ready", 32'(in_ready), 1);
      end
      check("issued_count", 32'(issued_count), 32'(hs % 65536));
      check("issued_count_w2", 32'(issued_count2), 32'(hs % 4));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    end
    if (rst) begin
      sb.delete();
      hs = 0;
      armed = 1;
    end else if (armed) begin
      if (out_valid && sb.size() != 0) begin
        check("out_op", 32'(out_op), 32'(sb[0].op));
        check("out_lhs", out_lhs, sb[0].lhs);
        check("out_rhs", out_rhs, sb[0].rhs);
        check("out_rd", 32'(out_rd), 32'(sb[0].rd));
        check("out_illegal", 32'(out_illegal), 32'(sb[0].ill));
      end
      if (out_valid && out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        hs++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_inst, in_pc, in_rs1, in_rs2));
    end
    rst_d = rst;
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b);
    bit acc = 0;
    int n = 0;
    in_valid = 1; in_inst = i; in_pc = pc; in_rs1 = a; in_rs2 = b;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic send_chk(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op, input logic [31:0] l,
                          input logic [31:0] r, input logic [4:0] rd, input logic ill);
    send(i, pc, a, b);
    @(negedge clk);
    check("dir_valid", 32'(out_valid), 1);
    check("dir_op", 32'(out_op), 32'(op));
    check("dir_lhs", out_lhs, l);
    check("dir_rhs", out_rhs, r);
    check("dir_rd", 32'(out_rd), 32'(rd));
    check("dir_illegal", 32'(out_illegal), 32'(ill));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    int f = $urandom_range(0, 2);
    case (k)
      0, 1, 2: w[6:0] = 7'h33;
      3, 4, 5: w[6:0] = 7'h13;
      6:       w[6:0] = 7'h37;
      7:       w[6:0] = 7'h17;
      default: ;
    endcase
    if (f == 0) w[31:25] = 7'h00;
    else if (f == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  initial begin
    logic [15:0] c0;
    int t0;
    rst = 1; in_valid = 1; in_inst = 32'h0031_00B3; in_pc = 0; in_rs1 = 1; in_rs2 = 2;
    repeat (3) @(posedge clk);
    #1;
    rst = 0; in_valid = 0;

    send_chk(32'h0031_00B3, 0, 32'hFFFF_FFFF, 1, 4'b0000, 32'hFFFF_FFFF, 1, 1, 0);
    send_chk(32'h4031_00B3, 0, 32'hFFFF_FFFF, 1, 4'b1000, 32'hFFFF_FFFF, 1, 1, 0);
    send_chk(32'hFFF1_0093, 0, 5, 0, 4'b0000, 5, 32'hFFFF_FFFF, 1, 0);
    send_chk(32'h4031_5093, 0, 32'hFFFF_FFFF, 0, 4'b1001, 32'hFFFF_FFFF, 3, 1, 0);
    send_chk(32'h1234_50B7, 0, 7, 9, 4'b0000, 0, 32'h1234_5000, 1, 0);
    send_chk(32'h0000_1097, 32'h100, 7, 9, 4'b0000, 32'h100, 32'h1000, 1, 0);
    drain();

    @(negedge clk);
    c0 = issued_count;
    @(posedge clk);
    #1;
    send_chk(32'h0000_0000, 0, 32'hAAAA_5555, 32'h1234_5678, 4'b0000, 0, 0, 0, 1);
    send_chk(32'h0231_00B3, 0, 32'hAAAA_5555, 32'h1234_5678, 4'b0000, 0, 0, 1, 1);
    drain();
    @(negedge clk);
    check("illegal_count", 32'(issued_count), 32'(c0 + 16'd2));

    // Backpressure: hold A for 3 cycles while B waits, then swap in the same cycle.
    @(posedge clk);
    force_rdy = 0;
    @(posedge clk);
    #1;
    send(32'h0020_8133, 0, 32'h1111_1111, 32'h2222_2222);
    fork
      send(32'h0020_81B3, 0, 32'h3333_3333, 32'h4444_4444);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 0);
          check("stall_lhs", out_lhs, 32'h1111_1111);
          check("stall_rd", 32'(out_rd), 2);
        end
        force_rdy = 1;
      end
    join
    @(negedge clk);
    check("swap_valid", 32'(out_valid), 1);
    check("swap_lhs", out_lhs, 32'h3333_3333);
    @(posedge clk);
    #1;

    t0 = cyc;
    for (int k = 0; k < 4; k++) send(rand_inst(), $urandom, $urandom, $urandom);
    check("stream_cycles", 32'(cyc - t0), 4);
    drain();

    // Reset with a pending transaction.
    force_rdy = 0;
    @(posedge clk);
    #1;
    send(32'h0031_00B3, 0, 5, 6);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    force_rdy = 1;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_count", 32'(issued_count), 0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++) send(rand_inst(), $urandom, $urandom, $urandom);
    drain();
    @(negedge clk);
    check("wrap_count_w2", 32'(issued_count2), 1);
    check("count_5", 32'(issued_count), 5);
    @(posedge clk);
    #1;

    rand_rdy = 1;
    for (int k = 0; k < 400; k++) begin
      send(rand_inst(), $urandom, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 0;
    drain();
    drain();
    @(negedge clk);
    check("final_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
